// File: rtl/block_repeat.sv
// block_repeat: captures BLOCK_SIZE-beat blocks into a ping-pong buffer and
// replays each block REPEAT times, in arrival order, through a registered
// output stage with a one-entry skid buffer.
module block_repeat #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 1,
    parameter int BLOCK_SIZE = 4,
    parameter int REPEAT     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           out_block_last
);

    localparam int W     = CHANNELS * DATA_WIDTH;
    localparam int IW    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int RW    = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    // Rounded up to a power of two so every index value addresses a real word.
    localparam int DEPTH = 1 << IW;

    localparam logic [IW-1:0] IDX_LAST = IW'(BLOCK_SIZE - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);

    typedef enum logic [1:0] {
        B_EMPTY,
        B_FILLING,
        B_FULL,
        B_READING
    } bank_st_t;

    bank_st_t st_q [2];
    bank_st_t st_d [2];

    logic [W-1:0] mem [2][DEPTH];

    // Writer side
    logic          wr_bank;
    logic [IW-1:0] wr_idx;
    logic          wr_fire;
    logic          wr_last;

    // Reader side
    logic          rd_bank;
    logic [IW-1:0] rd_idx;
    logic [RW-1:0] rep_cnt;
    logic          rd_avail;
    logic          rd_idx_last;
    logic          rep_last;
    logic          issue;
    logic          issue_rdy;
    logic          rd_done;

    // Issued beat (memory read register)
    logic [W-1:0]  data_p1;
    logic          last_p1;
    logic          blast_p1;
    logic          vld_p1;

    // Output register and skid entry
    logic [W-1:0]  data_p2;
    logic          last_p2;
    logic          blast_p2;
    logic          vld_p2;
    logic [W-1:0]  skid_data_p2;
    logic          skid_last_p2;
    logic          skid_blast_p2;
    logic          skid_vld_p2;

    // A bank accepts writes until it holds a complete block; reset blocks input.
    assign in_ready = !rst && ((st_q[wr_bank] == B_EMPTY) || (st_q[wr_bank] == B_FILLING));
    assign wr_fire  = in_valid && in_ready;
    assign wr_last  = (wr_idx == IDX_LAST);

    assign rd_avail    = (st_q[rd_bank] == B_FULL) || (st_q[rd_bank] == B_READING);
    assign rd_idx_last = (rd_idx == IDX_LAST);
    assign rep_last    = (rep_cnt == REP_LAST);
    // The p1 register can take a beat when empty, or when its beat moves on
    // this cycle (it always moves on while the skid entry is free).
    assign issue_rdy   = !vld_p1 || !skid_vld_p2;
    assign issue       = rd_avail && issue_rdy;
    assign rd_done     = issue && rd_idx_last && rep_last;

    // Bank state transitions; a bank is never written and read in the same cycle.
    always_comb begin
        st_d[0] = st_q[0];
        st_d[1] = st_q[1];
        for (int b = 0; b < 2; b++) begin
            if (wr_fire && (wr_bank == 1'(b))) begin
                st_d[b] = wr_last ? B_FULL : B_FILLING;
            end
            if (issue && (rd_bank == 1'(b))) begin
                st_d[b] = rd_done ? B_EMPTY : B_READING;
            end
        end
    end

    // Bank state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q[0] <= B_EMPTY;
            st_q[1] <= B_EMPTY;
        end else begin
            st_q[0] <= st_d[0];
            st_q[1] <= st_d[1];
        end
    end

    // Write pointer: fills one bank, then moves to the other.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else if (wr_fire) begin
            if (wr_last) begin
                wr_idx  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_idx  <= wr_idx + 1'b1;
            end
        end
    end

    // Block storage; contents need no reset because bank states gate all reads.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_idx] <= in_data;
        end
    end

    // Read pointer: walks the block REPEAT times, then frees the bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bank <= 1'b0;
            rd_idx  <= '0;
            rep_cnt <= '0;
        end else if (issue) begin
            if (rd_idx_last) begin
                rd_idx <= '0;
                if (rep_last) begin
                    rep_cnt <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end else begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    // ---- p1: issued beat, flags decided at issue time ----
    // Valid of the issued-beat register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (issue_rdy) begin
            vld_p1 <= issue;
        end
    end

    // Payload of the issued-beat register.
    always_ff @(posedge clk) begin
        if (issue) begin
            data_p1  <= mem[rd_bank][rd_idx];
            last_p1  <= rd_idx_last;
            blast_p1 <= rd_idx_last && rep_last;
        end
    end

    // ---- p2: output register with one-entry skid ----
    // Output register drains the skid first; while stalled, p1 parks in the skid.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2      <= 1'b0;
            data_p2     <= '0;
            last_p2     <= 1'b0;
            blast_p2    <= 1'b0;
            skid_vld_p2 <= 1'b0;
        end else if (!vld_p2 || out_ready) begin
            if (skid_vld_p2) begin
                data_p2     <= skid_data_p2;
                last_p2     <= skid_last_p2;
                blast_p2    <= skid_blast_p2;
                vld_p2      <= 1'b1;
                skid_vld_p2 <= 1'b0;
            end else if (vld_p1) begin
                data_p2  <= data_p1;
                last_p2  <= last_p1;
                blast_p2 <= blast_p1;
                vld_p2   <= 1'b1;
            end else begin
                vld_p2   <= 1'b0;
            end
        end else if (vld_p1 && !skid_vld_p2) begin
            skid_vld_p2 <= 1'b1;
        end
    end

    // Skid payload captures p1 only while the output register is stalled.
    always_ff @(posedge clk) begin
        if (vld_p2 && !out_ready && vld_p1 && !skid_vld_p2) begin
            skid_data_p2  <= data_p1;
            skid_last_p2  <= last_p1;
            skid_blast_p2 <= blast_p1;
        end
    end

    assign out_data       = data_p2;
    assign out_valid      = vld_p2;
    assign out_last       = last_p2;
    assign out_block_last = blast_p2;

endmodule

// File: doc/block_repeat.md
# block_repeat

Stream repeater that captures a block of `BLOCK_SIZE` beats, each `CHANNELS` lanes of `DATA_WIDTH` bits, and replays the whole block `REPEAT` times in order before moving to the next block. It is the block-level successor to the single-element repeater. Typical uses are tiled matmul/attention datapaths, where a row or tile of one operand must be re-streamed once per tile of the other operand. Storage is double-buffered (ping-pong), so the next block can be filled while the current one replays. The output is registered through a skid stage.

## Interface
- `DATA_WIDTH`, 32, bits per lane
- `CHANNELS`, 1, parallel lanes per beat
- `BLOCK_SIZE`, 4, beats per block (≥1)
- `REPEAT`, 2, number of times each block is emitted (≥1)
- `clk`  in  1  clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  `CHANNELS*DATA_WIDTH`  input beat; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`
- `out_data`  out  `CHANNELS*DATA_WIDTH`  replayed beat
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  output beat consumed when `out_valid && out_ready`
- `out_last`  out  1  high on the final beat of each repetition (beat index `BLOCK_SIZE-1`)
- `out_block_last`  out  1  high only on the final beat of the final repetition

## Operation
- Two banks, each `BLOCK_SIZE` x `CHANNELS*DATA_WIDTH`. Each bank has one state:
  - EMPTY -> FILLING on the first accepted write.
  - FILLING -> FULL when beat `BLOCK_SIZE-1` is written. With `BLOCK_SIZE`=1, EMPTY -> FULL directly.
  - FULL -> READING when the reader selects the bank.
  - READING -> EMPTY after the last beat of the last repetition is transferred into the output stage.
- Writer:
  - Registers `wr_bank` and `wr_idx`.
  - `in_ready` = (state of `wr_bank` is EMPTY or FILLING) and not `rst`.
  - `wr_idx` increments per accepted beat. On reaching `BLOCK_SIZE-1` it wraps to 0 and `wr_bank` toggles.
- Reader:
  - Registers `rd_bank`, `rd_idx` and `rep_cnt`.
  - Issues beat `rd_idx` of `rd_bank` into the output skid stage whenever the bank is FULL/READING and the skid stage is ready.
  - `rd_idx` wraps at `BLOCK_SIZE-1`, and each wrap increments `rep_cnt`.
  - When `rep_cnt==REPEAT-1` and `rd_idx==BLOCK_SIZE-1` issue:
    - `rep_cnt` and `rd_idx` return to 0;
    - the bank goes EMPTY at the next edge;
    - `rd_bank` toggles.
- Blocks are emitted strictly in arrival order. Beats within a block are emitted in index order, and lanes are never reordered.
- Counters: `rd_idx` and `wr_idx` are `max(1,$clog2(BLOCK_SIZE))` bits wide; `rep_cnt` is `max(1,$clog2(REPEAT))` bits wide. Comparisons are equality against the parameter minus 1, so non-power-of-2 sizes must wrap correctly.
- `out_last` and `out_block_last` are computed at issue time and carried through the skid stage alongside the data.
- `REPEAT==1` is not a passthrough: blocks are still buffered, and `out_last==out_block_last` on every block-final beat.
- Simultaneous events: a write completing one bank and a read freeing the other bank in the same cycle both take effect. No combinational path from `out_ready` to `in_ready`, because a freed bank becomes writable one cycle after the freeing transfer.

## Timing
- Reset (while `rst` high and the first cycle after):
  - `out_valid`=0, `out_last`=0, `out_block_last`=0, `out_data`=0;
  - `in_ready`=0 while `rst` high, 1 from the first cycle after deassertion;
  - both banks EMPTY; all pointers and counters 0.
- Reset mid-operation discards all buffered data and any in-flight output beat; no partial block is ever emitted after reset.
- Latency: last input beat of a block accepted at edge t. With the bank selected and `out_ready` high, the first output beat of that block is valid after edge t+2 (2 cycles).
- Throughput: with `out_ready` held high, output sustains 1 beat/cycle across block boundaries once the next block is FULL. Input sustains `BLOCK_SIZE` beats per `REPEAT*BLOCK_SIZE` cycles.
- Both banks FULL/READING: `in_ready`=0 until the reading bank frees.
- Backpressure: while `out_valid && !out_ready`, `out_data`, `out_last` and `out_block_last` hold stable. The skid stage absorbs one extra in-flight beat, and no beat is lost or duplicated.

## Test plan
- DATA_WIDTH=8, CHANNELS=2, BLOCK_SIZE=3, REPEAT=2. Input beats {0x0201,0x0403,0x0605}, `out_ready`=1 -> output 0x0201,0x0403,0x0605,0x0201,0x0403,0x0605. `out_last` on beats 3 and 6, `out_block_last` on beat 6 only. First `out_valid` 2 cycles after the third input handshake.
- BLOCK_SIZE=4, REPEAT=3, three back-to-back blocks A,B,C, `out_ready`=1 -> 36 output beats with no bubbles after the first. `in_ready` drops while both banks are occupied and rises exactly 1 cycle after the last beat of A's third repetition is issued.
- Random `out_ready` (50%) and random `in_valid`, 200 blocks, BLOCK_SIZE=5, REPEAT=3 -> output equals a scoreboard of each block repeated 3x. Data stays stable under stall.
- BLOCK_SIZE=1, REPEAT=1, 10 input values -> the same 10 values out, with `out_last`=`out_block_last`=1 on every beat.
- Assert `rst` for 1 cycle after 2 beats of the 2nd repetition of a BLOCK_SIZE=4 block -> `out_valid`=0 next cycle. The next emitted data is solely the first post-reset block.
- BLOCK_SIZE=3, REPEAT=5 (non-power-of-2 wrap) -> exactly 15 beats per block, and `rep_cnt` never aliases.
